// File: rtl/shift_reg_cfg_pkg.sv
// rtl/shift_reg_cfg_pkg.sv - shared constants and state encoding for the config shift register sequencer
package shift_reg_cfg_pkg;

   localparam int DEF_WIDTH   = 9;
   localparam int DEF_CLK_DIV = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_SHIFT_LO = 3'd1;
   localparam state_t ST_SHIFT_HI = 3'd2;
   localparam state_t ST_HOLD     = 3'd3;
   localparam state_t ST_LATCH    = 3'd4;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_cfg_ctrl_rr_arbiter.sv
// rtl/shift_reg_cfg_ctrl_rr_arbiter.sv - round-robin arbiter granting one requester per advance strobe
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   logic [IDW-1:0] ptr;
   logic           found;
   int             cand;

   // Search starts one past the last winner and wraps, so the last winner has lowest priority.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      cand     = 0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = (int'(ptr) + off) % NREQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_id    = IDW'(cand);
         end
      end
   end

   // Pointer remembers the most recent winner; reset value gives requester 0 first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= IDW'(NREQ - 1);
      end else if (advance) begin
         ptr <= grant_id;
      end
   end

endmodule

// File: rtl/shift_reg_cfg_ctrl.sv
// rtl/shift_reg_cfg_ctrl.sv - arbitrates config words and serializes them MSB-first into the PLL shift register
module shift_reg_cfg_ctrl
   import shift_reg_cfg_pkg::*;
#(
   parameter int  WIDTH   = DEF_WIDTH,
   parameter int  NREQ    = 2,
   parameter int  CLK_DIV = DEF_CLK_DIV,
   localparam int IDW     = idx_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  sclk,
   output logic                  sdata,
   output logic                  en,
   output logic                  latch,
   output logic                  busy,
   output logic                  done,
   output logic [IDW-1:0]        done_id
);

   localparam int             DCW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
   localparam logic [BCW-1:0] BIT_TOP  = BCW'(WIDTH - 1);

   state_t           state;
   logic [DCW-1:0]   div_cnt;
   logic [BCW-1:0]   bit_idx;
   logic [WIDTH-1:0] word;
   logic [IDW-1:0]   id_q;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_id;
   logic             accept;
   logic             div_end;
   logic             shifting;

   // A grant is only offered while idle and out of reset.
   assign accept    = (state == ST_IDLE) && (|req_valid) && !rst;
   assign req_ready = accept ? grant : '0;
   assign div_end   = (div_cnt == DIV_LAST);

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req_valid),
      .advance  (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // Frame sequencer: every phase lasts CLK_DIV clocks; bit index steps down only when sclk falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_idx <= '0;
         word    <= '0;
         id_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  word    <= req_data[int'(grant_id)*WIDTH +: WIDTH];
                  id_q    <= grant_id;
                  bit_idx <= BIT_TOP;
                  div_cnt <= '0;
                  state   <= ST_SHIFT_LO;
               end
            end
            ST_SHIFT_LO: begin
               if (div_end) begin
                  div_cnt <= '0;
                  state   <= ST_SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + DCW'(1);
               end
            end
            ST_SHIFT_HI: begin
               if (div_end) begin
                  div_cnt <= '0;
                  if (bit_idx == '0) begin
                     state <= ST_HOLD;
                  end else begin
                     bit_idx <= bit_idx - BCW'(1);
                     state   <= ST_SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + DCW'(1);
               end
            end
            ST_HOLD: begin
               if (div_end) begin
                  div_cnt <= '0;
                  state   <= ST_LATCH;
               end else begin
                  div_cnt <= div_cnt + DCW'(1);
               end
            end
            ST_LATCH: begin
               word  <= '0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Serial pins decode straight from state so an asynchronous reset clears them at once.
   always_comb begin
      shifting = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
      sclk     = (state == ST_SHIFT_HI);
      en       = shifting || (state == ST_HOLD);
      sdata    = shifting && word[bit_idx];
      latch    = (state == ST_LATCH);
      done     = (state == ST_LATCH);
      busy     = (state != ST_IDLE);
      done_id  = (state == ST_LATCH) ? id_q : '0;
   end

endmodule

// File: tb/tb_shift_reg_cfg_ctrl.sv
// tb/tb_shift_reg_cfg_ctrl.sv - directed self-checking bench for shift_reg_cfg_ctrl
module tb_shift_reg_cfg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [17:0] req_data;
   logic [1:0]  req_ready;
   logic        sclk, sdata, en, latch, busy, done;
   logic [0:0]  done_id;

   logic [1:0]  b_req_valid;
   logic [17:0] b_req_data;
   logic [1:0]  b_req_ready;
   logic        b_sclk, b_sdata, b_en, b_latch, b_busy, b_done;
   logic [0:0]  b_done_id;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // monitor state, DUT A (CLK_DIV=4)
   logic [8:0] sr = '0;
   logic       sclk_d = 1'b0;
   int ng = 0, nd = 0, nrise = 0, rdy_bad = 0;
   int gid[64], t_acc[64], t_lat[64], did[64], dq[64], lat_en[64], lat_nrise[64];

   // monitor state, DUT B (CLK_DIV=1)
   logic [8:0] b_sr = '0;
   logic       b_sclk_d = 1'b0;
   int b_ng = 0, b_nd = 0, b_nrise = 0, b_t_acc = 0, b_t_lat = 0, b_did = 0, b_dq = 0;
   int b_rise_prev = 0, b_rise_last = 0;

   shift_reg_cfg_ctrl #(.WIDTH(9), .NREQ(2), .CLK_DIV(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .sclk      (sclk),
      .sdata     (sdata),
      .en        (en),
      .latch     (latch),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id)
   );

   shift_reg_cfg_ctrl #(.WIDTH(9), .NREQ(2), .CLK_DIV(1)) u_dut_div1 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (b_req_valid),
      .req_data  (b_req_data),
      .req_ready (b_req_ready),
      .sclk      (b_sclk),
      .sdata     (b_sdata),
      .en        (b_en),
      .latch     (b_latch),
      .busy      (b_busy),
      .done      (b_done),
      .done_id   (b_done_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // external 9-bit shift register model plus grant/latch logging, DUT A
   always @(negedge clk) begin
      if (en && sclk && !sclk_d) begin
         sr = {sr[7:0], sdata};
         nrise++;
      end
      sclk_d = sclk;
      if ((req_ready & req_valid) != 2'b00 && ng < 64) begin
         gid[ng]   = req_ready[1] ? 1 : 0;
         t_acc[ng] = cyc;
         ng++;
         nrise = 0;
      end
      if (busy && req_ready != 2'b00) rdy_bad++;
      if (latch && nd < 64) begin
         t_lat[nd]     = cyc;
         did[nd]       = int'(done_id);
         dq[nd]        = int'(sr);
         lat_en[nd]    = int'(en);
         lat_nrise[nd] = nrise;
         nd++;
      end
   end

   // same model for DUT B
   always @(negedge clk) begin
      if (b_en && b_sclk && !b_sclk_d) begin
         b_sr = {b_sr[7:0], b_sdata};
         b_nrise++;
         b_rise_prev = b_rise_last;
         b_rise_last = cyc;
      end
      b_sclk_d = b_sclk;
      if ((b_req_ready & b_req_valid) != 2'b00) begin
         b_t_acc = cyc;
         b_ng++;
         b_nrise = 0;
      end
      if (b_latch) begin
         b_t_lat = cyc;
         b_did   = int'(b_done_id);
         b_dq    = int'(b_sr);
         b_nd++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ng(input int target, input int budget, input string tag);
      int k = 0;
      while (ng < target && k < budget) begin
         step(1);
         k++;
      end
      check(tag, 32'(ng >= target), 32'd1);
   endtask

   task automatic wait_nd(input int target, input int budget, input string tag);
      int k = 0;
      while (nd < target && k < budget) begin
         step(1);
         k++;
      end
      check(tag, 32'(nd >= target), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   int bg, bd, k, nd_before, rdy_base;
   logic [8:0] words[2];

   initial begin
      rst         = 1'b1;
      req_valid   = 2'b00;
      req_data    = '0;
      b_req_valid = 2'b00;
      b_req_data  = '0;
      step(2);

      // reset state, with requests pending during reset
      req_valid = 2'b11;
      step(1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_sdata", 32'(sdata), 0);
      check("rst_en", 32'(en), 0);
      check("rst_latch", 32'(latch), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_done_id", 32'(done_id), 0);
      check("rst_ready", 32'(req_ready), 0);
      req_valid = 2'b00;
      rst = 1'b0;
      step(2);

      // single word 1A5 from requester 0
      bg = ng; bd = nd;
      req_data[8:0] = 9'h1A5;
      req_valid     = 2'b01;
      wait_ng(bg + 1, 50, "t1_grant");
      req_valid = 2'b00;
      step(5);
      check("t1_busy_mid", 32'(busy), 1);
      check("t1_en_mid", 32'(en), 1);
      wait_nd(bd + 1, 200, "t1_done");
      check("t1_gid", gid[bg], 0);
      check("t1_latency", t_lat[bd] - t_acc[bg], 77);
      check("t1_done_id", did[bd], 0);
      check("t1_q", dq[bd], 32'h1A5);
      check("t1_nrise", lat_nrise[bd], 9);
      check("t1_en_at_latch", lat_en[bd], 0);
      check("t1_busy_after", 32'(busy), 0);

      // both requesters held from reset: grants alternate
      do_reset();
      bg = ng; bd = nd;
      words[0] = 9'h0AA;
      words[1] = 9'h155;
      req_data  = {words[1], words[0]};
      req_valid = 2'b11;
      wait_ng(bg + 4, 400, "t2_grants");
      req_valid = 2'b00;
      wait_nd(bd + 4, 400, "t2_done");
      for (int i = 0; i < 4; i++) begin
         check("t2_gid", gid[bg+i], i % 2);
         check("t2_latency", t_lat[bd+i] - t_acc[bg+i], 77);
         check("t2_done_id", did[bd+i], i % 2);
         check("t2_q", dq[bd+i], 32'(words[i%2]));
         if (i < 3) check("t2_gap", t_acc[bg+i+1] - t_lat[bd+i], 1);
      end

      // requester 1 back-to-back words
      bg = ng; bd = nd;
      req_data[17:9] = 9'h0FF;
      req_valid      = 2'b10;
      wait_ng(bg + 1, 50, "t3_grant0");
      req_data[17:9] = 9'h100;
      wait_ng(bg + 2, 200, "t3_grant1");
      req_valid = 2'b00;
      wait_nd(bd + 2, 200, "t3_done");
      check("t3_gid0", gid[bg], 1);
      check("t3_gid1", gid[bg+1], 1);
      check("t3_done_id0", did[bd], 1);
      check("t3_done_id1", did[bd+1], 1);
      check("t3_q0", dq[bd], 32'h0FF);
      check("t3_q1", dq[bd+1], 32'h100);
      check("t3_gap", t_acc[bg+1] - t_lat[bd], 1);

      // reset after the 4th sclk rising edge aborts the frame
      bg = ng;
      req_data[8:0] = 9'h0F0;
      req_valid     = 2'b01;
      wait_ng(bg + 1, 50, "t4_grant");
      req_valid = 2'b00;
      k = 0;
      while (nrise < 4 && k < 100) begin
         step(1);
         k++;
      end
      check("t4_reach_rise4", 32'(nrise >= 4), 1);
      nd_before = nd;
      rst = 1'b1;
      #1;
      check("t4_sclk", 32'(sclk), 0);
      check("t4_sdata", 32'(sdata), 0);
      check("t4_en", 32'(en), 0);
      check("t4_busy", 32'(busy), 0);
      step(3);
      rst = 1'b0;
      step(1);
      check("t4_no_done", nd, nd_before);
      bg = ng; bd = nd;
      req_data  = {9'h1FF, 9'h055};
      req_valid = 2'b11;
      wait_ng(bg + 1, 50, "t4_regrant");
      req_valid = 2'b00;
      wait_nd(bd + 1, 200, "t4_done");
      check("t4_gid", gid[bg], 0);
      check("t4_q", dq[bd], 32'h055);
      check("t4_done_id", did[bd], 0);
      check("t4_latency", t_lat[bd] - t_acc[bg], 77);
      check("t4_one_done", nd - bd, 1);

      // requester 1 arrives mid-frame of requester 0
      bg = ng; bd = nd;
      rdy_base = rdy_bad;
      req_data[8:0] = 9'h133;
      req_valid     = 2'b01;
      wait_ng(bg + 1, 50, "t6_grant0");
      req_valid = 2'b00;
      step(10);
      req_data[17:9] = 9'h0C3;
      req_valid      = 2'b10;
      step(1);
      check("t6_ready_mid", 32'(req_ready), 0);
      wait_ng(bg + 2, 200, "t6_grant1");
      req_valid = 2'b00;
      wait_nd(bd + 2, 200, "t6_done");
      check("t6_ready_while_busy", rdy_bad, rdy_base);
      check("t6_gid1", gid[bg+1], 1);
      check("t6_accept_after_latch", t_acc[bg+1] - t_lat[bd], 1);
      check("t6_q0", dq[bd], 32'h133);
      check("t6_q1", dq[bd+1], 32'h0C3);
      check("t6_done_id1", did[bd+1], 1);

      // CLK_DIV=1 instance, word 001
      b_req_data[8:0] = 9'h001;
      b_req_valid     = 2'b01;
      k = 0;
      while (b_ng < 1 && k < 20) begin
         step(1);
         k++;
      end
      b_req_valid = 2'b00;
      k = 0;
      while (b_nd < 1 && k < 100) begin
         step(1);
         k++;
      end
      check("t5_done", 32'(b_nd), 1);
      check("t5_latency", b_t_lat - b_t_acc, 20);
      check("t5_q", b_dq, 32'h001);
      check("t5_nrise", b_nrise, 9);
      check("t5_sclk_period", b_rise_last - b_rise_prev, 2);
      check("t5_done_id", b_did, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
